aw_slave_fifo: RTL and testbench
================================

Name: aw_slave_fifo

Overview:
Slave-side receiver for the AXI4-Lite write address (AW) channel, directly downstream of the write address master. Drives AWREADY, accepts AWADDR/AWPROT on each handshake and queues them in a small FIFO. Presents accepted addresses to the slave's write-data/response stage through a valid/ready interface. Decouples master address issue from slave write completion.

Parameters:
ADDR_W, 32, width of AWADDR and stored address.
DEPTH, 4, number of queued addresses; power of two, >= 2.
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden).

Ports:
ACLK  input  1  single clock; all state updates on rising edge.
ARESETn  input  1  reset: asynchronous, active-high (asserted = 1 resets, despite the name).
AWVALID  input  1  master address valid.
AWADDR  input  ADDR_W  master write address.
AWPROT  input  3  master protection attributes.
AWREADY  output  1  slave can accept an address this cycle.
wa_valid  output  1  queued address available to write stage.
wa_addr  output  ADDR_W  head-of-queue address.
wa_prot  output  3  head-of-queue AWPROT.
wa_err  output  1  head-of-queue protection violation flag (see Optional Feature).
wa_ready  input  1  write stage consumes head entry.
count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (asserted at any time, including mid-transfer): wr_ptr=rd_ptr=0, count=0, all entries discarded; AWREADY=0 while reset asserted; wa_valid=0, wa_addr=0, wa_prot=0, wa_err=0. First cycle after deassertion: AWREADY=1.
- AWREADY = (count != DEPTH) and not in reset; derived from registered count only, never from AWVALID.
- Push: AWVALID && AWREADY at a rising edge -> store {AWADDR, AWPROT, err} at wr_ptr, wr_ptr+1 mod DEPTH.
- Pop: wa_valid && wa_ready at a rising edge -> rd_ptr+1 mod DEPTH.
- Show-ahead: wa_valid = (count != 0); wa_addr/wa_prot/wa_err = entry at rd_ptr. When count==0, outputs hold 0.
- Latency: address accepted at edge N appears on wa_* after edge N (visible in cycle N+1). No same-cycle bypass.
- Simultaneous push and pop: count unchanged; both pointers advance. Allowed at any 0<count<DEPTH.
- Full (count==DEPTH): AWREADY=0; AWVALID held by the master is not accepted; a pop in that cycle makes AWREADY=1 next cycle.
- Empty: wa_ready ignored, no pointer movement.
- Pointers wrap modulo DEPTH; count is updated as +1 push-only, -1 pop-only, else held.
- AWVALID without handshake: no state change; AWADDR is sampled only on handshake.

Optional Feature:
Macro AW_PROT_CHECK_EN.
- Defined: on push, err = AWPROT[1] (non-secure access); the entry is still queued and the handshake still completes. wa_err carries the flag for the write stage to return SLVERR.
- Not defined: err stored as 0; wa_err is constant 0. Port list is identical in both builds.

Decomposition:
- Shared package axi_lite_pkg: ADDR_W default, prot_t (3-bit typedef), aw_entry_t struct {addr, prot, err}, PROT_NONSECURE_BIT=1 constant.
- One sub-module: aw_fifo_mem, DEPTH x aw_entry_t register array with write port (en, idx, data) and async read port (idx). Pointer, count and handshake logic stay in aw_slave_fifo.

Test Plan:
- Reset then single write: AWVALID=1, AWADDR=0x0000_1000, AWPROT=0 for one edge -> count=1, wa_valid=1, wa_addr=0x1000 the next cycle; wa_ready=1 -> count=0, wa_valid=0.
- Fill: 4 back-to-back addresses 0x10,0x20,0x30,0x40 with wa_ready=0 -> count=4, AWREADY=0; 5th address 0x50 held on AWVALID is not accepted until one pop, then accepted; drain order is 0x10..0x50.
- Concurrent push/pop at count=2 for 8 cycles with incrementing addresses -> count stays 2, output order matches input order, pointers wrap twice without loss.
- Reset mid-operation: count=3, ARESETn pulsed high for half a cycle between edges -> immediately count=0, wa_valid=0, AWREADY=0; after release AWREADY=1 and the old entries never appear.
- AW_PROT_CHECK_EN defined: push AWPROT=3'b010 then 3'b000 -> wa_err=1 for the first entry and 0 for the second; not defined: wa_err=0 for both.
- Empty pop: wa_ready=1 with count=0 for 3 cycles -> count stays 0, pointers unchanged, a subsequent push of 0xABCD appears correctly.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types for the slave write-address path.
// Entry layout carries the optional protection flag (AW_PROT_CHECK_EN).
package axi_lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int PROT_NONSECURE_BIT = 1;

    typedef logic [2:0] prot_t;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        prot_t                 prot;
        logic                  err;
    } aw_entry_t;

endpackage

// File: rtl/aw_fifo_mem.sv
// Register-array storage for queued write-address entries.
// One synchronous write port, one asynchronous read port.
module aw_fifo_mem
    import axi_lite_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  aw_entry_t        wdata,
    input  logic [IDX_W-1:0] ridx,
    output aw_entry_t        rdata
);

    aw_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/aw_slave_fifo.sv
// AXI4-Lite AW-channel slave receiver with show-ahead address queue.
// Optional AW_PROT_CHECK_EN flags non-secure (AWPROT[1]) entries.
module aw_slave_fifo
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = axi_lite_pkg::AXI_ADDR_W,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              AWVALID,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [2:0]        AWPROT,
    output logic              AWREADY,
    output logic              wa_valid,
    output logic [ADDR_W-1:0] wa_addr,
    output logic [2:0]        wa_prot,
    output logic              wa_err,
    input  logic              wa_ready,
    output logic [CNT_W-1:0]  count
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    aw_entry_t        wr_entry;
    aw_entry_t        rd_entry;

    // ARESETn is active-high despite its name
    assign AWREADY  = !ARESETn && (count != CNT_W'(DEPTH));
    assign wa_valid = (count != '0);
    assign push     = AWVALID && AWREADY;
    assign pop      = wa_valid && wa_ready;

    always_comb begin
        wr_entry      = '0;
        wr_entry.addr = AXI_ADDR_W'(AWADDR);
        wr_entry.prot = prot_t'(AWPROT);
`ifdef AW_PROT_CHECK_EN
        wr_entry.err  = AWPROT[PROT_NONSECURE_BIT];
`else
        wr_entry.err  = 1'b0;
`endif
    end

    aw_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (ACLK),
        .we    (push),
        .widx  (wr_ptr),
        .wdata (wr_entry),
        .ridx  (rd_ptr),
        .rdata (rd_entry)
    );

    // Empty queue presents zeros rather than stale storage
    assign wa_addr = wa_valid ? ADDR_W'(rd_entry.addr) : '0;
    assign wa_prot = wa_valid ? rd_entry.prot : '0;
    assign wa_err  = wa_valid && rd_entry.err;

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_aw_slave_fifo.sv
// Directed-vector bench for aw_slave_fifo (DEPTH=4, ADDR_W=32).
// Build with +define+AW_PROT_CHECK_EN to exercise the protection flag.
module tb_aw_slave_fifo;

    logic        ACLK;
    logic        ARESETn;
    logic        AWVALID;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        AWREADY;
    logic        wa_valid;
    logic [31:0] wa_addr;
    logic [2:0]  wa_prot;
    logic        wa_err;
    logic        wa_ready;
    logic [2:0]  count;

    int vectors;
    int miscompares;

    aw_slave_fifo #(
        .ADDR_W (32),
        .DEPTH  (4)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .AWVALID  (AWVALID),
        .AWADDR   (AWADDR),
        .AWPROT   (AWPROT),
        .AWREADY  (AWREADY),
        .wa_valid (wa_valid),
        .wa_addr  (wa_addr),
        .wa_prot  (wa_prot),
        .wa_err   (wa_err),
        .wa_ready (wa_ready),
        .count    (count)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETn  = 1'b1;
        AWVALID  = 1'b0;
        AWADDR   = '0;
        AWPROT   = '0;
        wa_ready = 1'b0;
        step();
        step();
        vectors++;
        if (count !== 3'd0 || AWREADY !== 1'b0 || wa_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: count=%0d AWREADY=%b wa_valid=%b, need 0/0/0",
                     count, AWREADY, wa_valid);
        end
        vectors++;
        if (wa_addr !== 32'h0 || wa_prot !== 3'd0 || wa_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: addr=%h prot=%b err=%b, need zeros",
                     wa_addr, wa_prot, wa_err);
        end
        ARESETn = 1'b0;
        #1;
        vectors++;
        if (AWREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: AWREADY=%b, need 1", AWREADY);
        end
        step();
    endtask

    task automatic test_single();
        AWVALID = 1'b1;
        AWADDR  = 32'h0000_1000;
        AWPROT  = 3'b000;
        step();
        AWVALID = 1'b0;
        vectors++;
        if (count !== 3'd1 || wa_valid !== 1'b1 || wa_addr !== 32'h1000) begin
            miscompares++;
            $display("FAIL single_push: count=%0d valid=%b addr=%h, need 1/1/00001000",
                     count, wa_valid, wa_addr);
        end
        wa_ready = 1'b1;
        step();
        wa_ready = 1'b0;
        vectors++;
        if (count !== 3'd0 || wa_valid !== 1'b0 || wa_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL single_pop: count=%0d valid=%b addr=%h, need 0/0/0",
                     count, wa_valid, wa_addr);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            AWVALID = 1'b1;
            AWADDR  = 32'h10 * (i + 1);
            step();
        end
        AWADDR = 32'h50;
        vectors++;
        if (count !== 3'd4 || AWREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: count=%0d AWREADY=%b, need 4/0", count, AWREADY);
        end
        step();
        step();
        vectors++;
        if (count !== 3'd4 || wa_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL fill_hold: count=%0d head=%h, need 4/10", count, wa_addr);
        end
        wa_ready = 1'b1;
        step();
        wa_ready = 1'b0;
        vectors++;
        if (count !== 3'd3 || AWREADY !== 1'b1 || wa_addr !== 32'h20) begin
            miscompares++;
            $display("FAIL fill_pop_full: count=%0d AWREADY=%b head=%h, need 3/1/20",
                     count, AWREADY, wa_addr);
        end
        step();
        AWVALID = 1'b0;
        vectors++;
        if (count !== 3'd4) begin
            miscompares++;
            $display("FAIL fill_late_push: count=%0d, need 4", count);
        end
        wa_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (wa_valid !== 1'b1 || wa_addr !== 32'h20 + 32'h10 * i) begin
                miscompares++;
                $display("FAIL fill_drain[%0d]: valid=%b addr=%h, need 1/%h",
                         i, wa_valid, wa_addr, 32'h20 + 32'h10 * i);
            end
            step();
        end
        wa_ready = 1'b0;
        vectors++;
        if (count !== 3'd0 || wa_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_empty: count=%0d valid=%b, need 0/0", count, wa_valid);
        end
    endtask

    task automatic test_concurrent();
        int mism;
        mism = 0;
        AWVALID = 1'b1;
        AWADDR  = 32'h100;
        step();
        AWADDR  = 32'h101;
        step();
        wa_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            AWADDR = 32'h102 + k;
            vectors++;
            if (count !== 3'd2 || wa_addr !== 32'h100 + k) begin
                miscompares++;
                $display("FAIL concurrent[%0d]: count=%0d head=%h, need 2/%h",
                         k, count, wa_addr, 32'h100 + k);
            end
            step();
        end
        AWVALID = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (wa_valid !== 1'b1 || wa_addr !== 32'h108 + k) begin
                miscompares++;
                $display("FAIL concurrent_drain[%0d]: valid=%b head=%h, need 1/%h",
                         k, wa_valid, wa_addr, 32'h108 + k);
            end
            step();
        end
        wa_ready = 1'b0;
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL concurrent_empty: count=%0d, need 0", count);
        end
    endtask

    task automatic test_reset_mid();
        AWVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            AWADDR = 32'h200 + i;
            step();
        end
        AWVALID = 1'b0;
        vectors++;
        if (count !== 3'd3) begin
            miscompares++;
            $display("FAIL mid_prefill: count=%0d, need 3", count);
        end
        ARESETn = 1'b1;
        #2;
        vectors++;
        if (count !== 3'd0 || wa_valid !== 1'b0 || AWREADY !== 1'b0 || wa_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset: count=%0d valid=%b AWREADY=%b addr=%h, need 0/0/0/0",
                     count, wa_valid, AWREADY, wa_addr);
        end
        #3;
        ARESETn = 1'b0;
        #1;
        vectors++;
        if (AWREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_release: AWREADY=%b, need 1", AWREADY);
        end
        step();
        vectors++;
        if (wa_valid !== 1'b0 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL mid_stale: valid=%b count=%0d, need 0/0", wa_valid, count);
        end
        AWVALID = 1'b1;
        AWADDR  = 32'h300;
        step();
        AWVALID = 1'b0;
        vectors++;
        if (count !== 3'd1 || wa_addr !== 32'h300) begin
            miscompares++;
            $display("FAIL mid_fresh: count=%0d head=%h, need 1/300", count, wa_addr);
        end
        wa_ready = 1'b1;
        step();
        wa_ready = 1'b0;
    endtask

    task automatic test_prot();
        logic exp_err;
`ifdef AW_PROT_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        AWVALID = 1'b1;
        AWADDR  = 32'h400;
        AWPROT  = 3'b010;
        step();
        AWADDR  = 32'h404;
        AWPROT  = 3'b000;
        step();
        AWVALID = 1'b0;
        vectors++;
        if (count !== 3'd2 || wa_prot !== 3'b010 || wa_err !== exp_err) begin
            miscompares++;
            $display("FAIL prot_first: count=%0d prot=%b err=%b, need 2/010/%b",
                     count, wa_prot, wa_err, exp_err);
        end
        wa_ready = 1'b1;
        step();
        vectors++;
        if (wa_addr !== 32'h404 || wa_prot !== 3'b000 || wa_err !== 1'b0) begin
            miscompares++;
            $display("FAIL prot_second: addr=%h prot=%b err=%b, need 404/000/0",
                     wa_addr, wa_prot, wa_err);
        end
        step();
        wa_ready = 1'b0;
    endtask

    task automatic test_empty_pop();
        wa_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (count !== 3'd0 || wa_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL empty_pop[%0d]: count=%0d valid=%b, need 0/0",
                         i, count, wa_valid);
            end
        end
        wa_ready = 1'b0;
        AWVALID  = 1'b1;
        AWADDR   = 32'hABCD;
        step();
        AWVALID = 1'b0;
        vectors++;
        if (count !== 3'd1 || wa_addr !== 32'hABCD) begin
            miscompares++;
            $display("FAIL empty_then_push: count=%0d head=%h, need 1/abcd",
                     count, wa_addr);
        end
        wa_ready = 1'b1;
        step();
        wa_ready = 1'b0;
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL empty_final: count=%0d, need 0", count);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_fill();
        test_concurrent();
        test_reset_mid();
        test_prot();
        test_empty_pop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
